quad_step_decoder: RTL

// - Decodes asynchronous quadrature inputs (quad_a, quad_b) into step pulses with a direction flag.
// - Accumulates the pulses in a loadable position counter.
// - Sits on the input side of the counter datapath: its step/dir outputs use the

---
 rtl/quad_step_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, emits step/dir pulses, flags illegal
// transitions and keeps a loadable position count. Define QUAD_DEC_X4_EN for x4 counting (default x1).
module quad_step_decoder #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             load,
  input  logic [CNT_W-1:0] data_in,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0]             cur, prev;
  logic [SYNC_STAGES+1:0] fill;
  logic                   primed;

  logic fwd, rev, illegal;
  logic count_up, count_dn;
  logic step_d, err_d;

  // The synchronizers restart from 0 after reset, so prev only holds a genuine input
  // sample once they have refilled; decoding stays blanked until then.
  assign primed = fill[SYNC_STAGES+1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which makes the shift chains work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
      cur    <= '0;
      prev   <= '0;
      fill   <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], quad_a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], quad_b};
      cur    <= {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
      prev   <= cur;
      fill   <= {fill[SYNC_STAGES:0], 1'b1};
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fwd     = 1'b0;
    rev     = 1'b0;
    illegal = ((prev ^ cur) == 2'b11);
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
      default: ;
    endcase
  end

`ifdef QUAD_DEC_X4_EN
  assign count_up = fwd;
  assign count_dn = rev;
`else
  // x1: one count per cycle, taken on the B-low edge of channel A.
  assign count_up = fwd && (cur == 2'b00);
  assign count_dn = rev && (cur == 2'b10);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    step_d = 1'b0;
    err_d  = 1'b0;
    if (state == S_RUN && primed && enable) begin
      step_d = count_up | count_dn;
      err_d  = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step  <= 1'b0;
      err   <= 1'b0;
      dir   <= 1'b0;
      count <= '0;
    end else begin
      step <= step_d;
      err  <= err_d;
      if (step_d) begin
        dir <= count_dn;
      end
      // A load wins over a coincident step; the step still pulses and updates dir.
      if (enable && load) begin
        count <= data_in;
      end else if (step_d) begin
        count <= count_dn ? count - CNT_W'(1) : count + CNT_W'(1);
      end
    end
  end

endmodule
